posit_encoder: RTL and testbench
================================

// Module: posit_encoder
// PURPOSE
//  Stage-5 posit encoder; the responder to the pipeline controller's encoder_start/encode_done handshake.
//  Packs sign, scale and fraction into an N-bit posit bit-serially.
//  The packing emits regime run, terminator, exponent and fraction into the body one bit per cycle.
//  It then applies round-to-nearest-even and two's-complement negation.
//  Zero, NaR and saturation are encoded directly on a short fixed-latency path.
// PARAMETERS
//  N        16   posit width (>=8)
//  ES       2    exponent field width
//  FRAC_W   16   fraction width, hidden bit excluded
//  SCALE_W  8    signed scale width (scale = k*2^ES + e)
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous reset, active high
//  encoder_start  in   1        start pulse; sampled only in IDLE
//  is_zero        in   1        result is zero
//  is_nar         in   1        result is NaR (priority over is_zero)
//  sign           in   1        result sign
//  scale          in   SCALE_W  signed scale
//  frac           in   FRAC_W   fraction MSB-first, hidden bit removed
//  sticky_in      in   1        OR of upstream discarded fraction bits
//  posit_out      out  N        encoded posit; held until next completion
//  encode_done    out  1        one-cycle completion pulse
//  busy           out  1        high in every state except IDLE
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is synchronous, active high.
//  Reset at the next clk edge: state=IDLE, posit_out=0, encode_done=0, busy=0. This applies mid-operation too; the current job is discarded.
//  FSM states: IDLE, EMIT, ROUND, DONE.
//  IDLE, encoder_start=1: capture all inputs.
//   - k = scale>>>ES (arithmetic); e = scale[ES-1:0].
//   - is_nar: posit_out = 1 followed by N-1 zeros; go to DONE.
//   - else is_zero: posit_out = 0; go to DONE.
//   - else k >= N-2: body = all ones (maxpos); go to DONE.
//   - else k <= -(N-1): body = 0..01 (minpos); go to DONE.
//   - else: go to EMIT. Set run counter = k+1 ones if k>=0, else -k zeros.
//   - Load tail shift register = {e, frac}.
//  EMIT: lasts exactly N-1 cycles; a bit counter counts the body bits.
//   - Each cycle shifts one bit into the (N-1)-bit body LSB-side, in order:
//     - run bits (regime value);
//     - one terminator (inverse of the run);
//     - tail MSB-first. Each tail bit consumed shifts tail left; zeros fill once tail is exhausted.
//  ROUND: 1 cycle. Rounding (round-to-nearest-even):
//   - guard = tail MSB remaining; sticky = |(rest of tail) | sticky_in.
//   - round_up = guard & (body[0] | sticky).
//   - If body is all ones, no increment (never round to NaR).
//   - Minpos and larger never round to zero.
//  Sign (ROUND and the saturation paths): posit_out = {0, body}, negated (two's complement, N bits) when sign=1.
//  DONE: encode_done=1 for exactly one cycle, then IDLE. posit_out is valid when encode_done rises.
//  Latency from encoder_start sampled: N+1 cycles normal path; 1 cycle for NaR/zero/saturation.
//  Back-to-back: encoder_start is accepted again in the IDLE cycle following DONE.
//  Ignored inputs:
//   - encoder_start while busy is ignored (no queueing).
//   - Inputs other than encoder_start are don't-care outside the capture cycle.
// TESTING
//  1. scale=0, frac=0, sign=0 -> posit_out=16'h4000; encode_done 17 cycles after start.
//  2. scale=0, frac=0, sign=1 -> posit_out=16'hC000.
//  3. scale=0, rounding cases:
//     - frac=16'h0010 (tie, even LSB) -> 16'h4000.
//     - frac=16'h0030 -> 16'h4002.
//     - frac=16'h0010 with sticky_in=1 -> 16'h4001.
//  4. Special inputs:
//     - is_nar=1 together with is_zero=1 -> 16'h8000, done 1 cycle after start.
//     - is_zero only -> 16'h0000.
//  5. Saturation:
//     - scale=+100 -> 16'h7FFF.
//     - scale=-100 -> 16'h0001.
//     - scale=+100 with sign=1 -> 16'h8001.
//     - scale=56 (k=14), frac=16'hFFFF -> 16'h7FFF, no wrap to NaR.
//  6. Handshake and reset:
//     - rst pulsed mid-EMIT -> outputs 0, IDLE next cycle.
//     - encoder_start pulsed while busy -> ignored; exactly one encode_done.

Source files
------------

// File: rtl/posit_encoder.sv
// Bit-serial posit encoder: packs sign/scale/fraction into an N-bit posit with
// round-to-nearest-even; zero, NaR and regime saturation take a 1-cycle path.
module posit_encoder #(
  parameter int N       = 16,
  parameter int ES      = 2,
  parameter int FRAC_W  = 16,
  parameter int SCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      encoder_start,
  input  logic                      is_zero,
  input  logic                      is_nar,
  input  logic                      sign,
  input  logic signed [SCALE_W-1:0] scale,
  input  logic [FRAC_W-1:0]         frac,
  input  logic                      sticky_in,
  output logic [N-1:0]              posit_out,
  output logic                      encode_done,
  output logic                      busy
);

  localparam int TW    = ES + FRAC_W;
  localparam int CNT_W = $clog2(N) + 1;
  localparam int BIT_W = $clog2(N);
  localparam logic [N-2:0] MAXPOS = '1;
  localparam logic [N-2:0] MINPOS = {{(N-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_ROUND, S_DONE} state_t;

  state_t             state_q;
  logic [N-1:0]       posit_q;
  logic               done_q;
  logic               busy_q;
  logic [CNT_W-1:0]   run_cnt_q;
  logic               run_val_q;
  logic               term_done_q;
  logic [BIT_W-1:0]   bit_cnt_q;

  logic [N-2:0]       body_q;
  logic [TW-1:0]      tail_q;
  logic               sign_q;
  logic               sticky_q;

  logic signed [SCALE_W-1:0] k_s;
  int                 k_i;
  logic [CNT_W-1:0]   run_len_d;
  logic               emit_bit;
  logic               guard;
  logic               sticky;
  logic [N-2:0]       body_rnd_d;
  logic               capture;

  function automatic logic [N-2:0] round_rne(input logic [N-2:0] body,
                                             input logic g, input logic s);
    // An all-ones body is maxpos: incrementing it would wrap into NaR.
    if (g && (body[0] || s) && !(&body)) return body + 1'b1;
    return body;
  endfunction

  function automatic logic [N-1:0] apply_sign(input logic neg, input logic [N-2:0] body);
    logic [N-1:0] mag;
    mag = {1'b0, body};
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  assign k_s     = scale >>> ES;
  assign capture = (state_q == S_IDLE) && encoder_start;

  always_comb begin
    k_i       = int'(k_s);
    run_len_d = (k_i >= 0) ? CNT_W'(k_i + 1) : CNT_W'(-k_i);
  end

  // Regime run first, then its terminator, then the tail MSB-first.
  always_comb begin
    emit_bit = tail_q[TW-1];
    if (run_cnt_q != '0)  emit_bit = run_val_q;
    else if (!term_done_q) emit_bit = ~run_val_q;
  end

  always_comb begin
    guard      = tail_q[TW-1];
    sticky     = (|tail_q[TW-2:0]) | sticky_q;
    body_rnd_d = round_rne(body_q, guard, sticky);
  end

  // Datapath registers: captured at start, shifted while emitting.
  always_ff @(posedge clk) begin
    if (capture) begin
      body_q   <= '0;
      tail_q   <= {scale[ES-1:0], frac};
      sign_q   <= sign;
      sticky_q <= sticky_in;
    end else if (state_q == S_EMIT) begin
      body_q <= {body_q[N-3:0], emit_bit};
      if (run_cnt_q == '0 && term_done_q) tail_q <= tail_q << 1;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      posit_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      run_cnt_q   <= '0;
      run_val_q   <= 1'b0;
      term_done_q <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (encoder_start) begin
            busy_q      <= 1'b1;
            run_cnt_q   <= run_len_d;
            run_val_q   <= ~k_s[SCALE_W-1];
            term_done_q <= 1'b0;
            bit_cnt_q   <= '0;
            if (is_nar) begin
              posit_q <= {1'b1, {(N-1){1'b0}}};
              state_q <= S_DONE;
            end else if (is_zero) begin
              posit_q <= '0;
              state_q <= S_DONE;
            end else if (k_i >= N - 2) begin
              posit_q <= apply_sign(sign, MAXPOS);
              state_q <= S_DONE;
            end else if (k_i <= -(N - 1)) begin
              posit_q <= apply_sign(sign, MINPOS);
              state_q <= S_DONE;
            end else begin
              state_q <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (run_cnt_q != '0)   run_cnt_q   <= run_cnt_q - 1'b1;
          else if (!term_done_q) term_done_q <= 1'b1;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_W'(N - 2)) state_q <= S_ROUND;
        end
        S_ROUND: begin
          posit_q <= apply_sign(sign_q, body_rnd_d);
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign posit_out   = posit_q;
  assign encode_done = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_posit_encoder.sv
// Bench for posit_encoder: directed cases plus randomized jobs checked against
// an arithmetic reference model of posit packing and rounding.
module tb_posit_encoder;
  localparam int N = 16, ES = 2, FRAC_W = 16, SCALE_W = 8;

  logic clk = 1'b0;
  logic rst, encoder_start, is_zero, is_nar, sign, sticky_in;
  logic signed [SCALE_W-1:0] scale;
  logic [FRAC_W-1:0] frac;
  logic [N-1:0] posit_out;
  logic encode_done, busy;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  posit_encoder #(.N(N), .ES(ES), .FRAC_W(FRAC_W), .SCALE_W(SCALE_W)) dut (
    .clk(clk), .rst(rst), .encoder_start(encoder_start), .is_zero(is_zero),
    .is_nar(is_nar), .sign(sign), .scale(scale), .frac(frac),
    .sticky_in(sticky_in), .posit_out(posit_out), .encode_done(encode_done),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int regime_k(input int sc);
    int e;
    e = ((sc % (1 << ES)) + (1 << ES)) % (1 << ES);
    return (sc - e) / (1 << ES);
  endfunction

  // Builds the unbounded bit string regime|e|frac, keeps the top N-1 bits and
  // rounds the remainder to nearest even as a magnitude comparison.
  function automatic logic [N-1:0] model(input bit nar, input bit zero, input bit sgn,
                                         input int sc, input logic [FRAC_W-1:0] fr,
                                         input bit st);
    longint maxpos, bits, body, rem, twice, half2, mag;
    int e, k, len, r;
    maxpos = (longint'(1) << (N - 1)) - 1;
    if (nar) return N'(longint'(1) << (N - 1));
    if (zero) return '0;
    e = ((sc % (1 << ES)) + (1 << ES)) % (1 << ES);
    k = (sc - e) / (1 << ES);
    if (k >= N - 2) mag = maxpos;
    else if (k <= -(N - 1)) mag = 1;
    else begin
      bits = 0; len = 0;
      if (k >= 0) begin
        for (int i = 0; i < k + 1; i++) begin bits = bits * 2 + 1; len++; end
        bits = bits * 2; len++;
      end else begin
        for (int i = 0; i < -k; i++) begin bits = bits * 2; len++; end
        bits = bits * 2 + 1; len++;
      end
      bits = bits * (1 << ES) + e;
      bits = bits * (longint'(1) << FRAC_W) + longint'(fr);
      len  = len + ES + FRAC_W;
      r     = len - (N - 1);
      body  = bits >> r;
      rem   = bits - (body << r);
      twice = 2 * rem + st;
      half2 = longint'(1) << r;
      if (twice > half2 || (twice == half2 && body % 2 == 1)) body++;
      if (body > maxpos) body = maxpos;
      mag = body;
    end
    if (sgn) mag = ((longint'(1) << N) - mag) % (longint'(1) << N);
    return N'(mag);
  endfunction

  task automatic encode(input string tag, input bit nar, input bit zero, input bit sgn,
                        input int sc, input logic [FRAC_W-1:0] fr, input bit st,
                        input int exp_lat, input logic [N-1:0] exp_val);
    int lat;
    lat = 0;
    is_nar = nar; is_zero = zero; sign = sgn; scale = SCALE_W'(sc);
    frac = fr; sticky_in = st; encoder_start = 1'b1;
    @(posedge clk); #1;
    encoder_start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (encode_done) begin lat = c; break; end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check(tag, posit_out, exp_val);
  endtask

  initial begin
    int ndone, first, sc, k, lat;
    bit nz, nn, sg, st;
    logic [FRAC_W-1:0] fr;

    rst = 1'b1; encoder_start = 1'b0; is_zero = 1'b0; is_nar = 1'b0;
    sign = 1'b0; scale = '0; frac = '0; sticky_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_posit", posit_out, 0);
    check("reset_done", encode_done, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    encode("one_pos",   0, 0, 0,    0, 16'h0000, 0, N + 1, 16'h4000);
    encode("one_neg",   0, 0, 1,    0, 16'h0000, 0, N + 1, 16'hC000);
    encode("tie_even",  0, 0, 0,    0, 16'h0010, 0, N + 1, 16'h4000);
    encode("tie_odd",   0, 0, 0,    0, 16'h0030, 0, N + 1, 16'h4002);
    encode("sticky_up", 0, 0, 0,    0, 16'h0010, 1, N + 1, 16'h4001);
    encode("nar_zero",  1, 1, 0,    0, 16'h1234, 0, 1,     16'h8000);
    encode("zero",      0, 1, 1,    5, 16'h1234, 0, 1,     16'h0000);
    encode("sat_max",   0, 0, 0,  100, 16'h0000, 0, 1,     16'h7FFF);
    encode("sat_min",   0, 0, 0, -100, 16'h0000, 0, 1,     16'h0001);
    encode("sat_negmx", 0, 0, 1,  100, 16'h0000, 0, 1,     16'h8001);
    encode("k14_ffff",  0, 0, 0,   56, 16'hFFFF, 1, 1,     16'h7FFF);
    encode("k13_nonar", 0, 0, 0,   55, 16'hFFFF, 1, N + 1, 16'h7FFF);
    encode("k_m14",     0, 0, 0,  -56, 16'h0000, 0, N + 1, 16'h0001);

    // Reset in the middle of an emit discards the job.
    is_nar = 0; is_zero = 0; sign = 0; scale = '0; frac = 16'h0030; sticky_in = 0;
    encoder_start = 1'b1;
    @(posedge clk); #1;
    encoder_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("emit_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_posit", posit_out, 0);
    check("midrst_done", encode_done, 0);
    check("midrst_busy", busy, 0);
    ndone = 0;
    repeat (25) begin @(posedge clk); #1; if (encode_done) ndone++; end
    check("midrst_nodone", ndone, 0);
    encode("after_rst", 0, 0, 1, 0, 16'h0030, 0, N + 1, 16'hBFFE);

    // Start pulses while busy must be ignored.
    is_nar = 0; is_zero = 0; sign = 0; scale = '0; frac = 16'h0030; sticky_in = 0;
    encoder_start = 1'b1;
    @(posedge clk); #1;
    encoder_start = 1'b0;
    ndone = 0; first = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3 || c == 10) begin
        encoder_start = 1'b1; scale = 8'sd100; sign = 1'b1;
      end else begin
        encoder_start = 1'b0;
      end
      @(posedge clk); #1;
      if (encode_done) begin ndone++; if (first == 0) first = c; end
    end
    encoder_start = 1'b0;
    check("busy_one_done", ndone, 1);
    check("busy_latency", first, N + 1);
    check("busy_value", posit_out, 16'h4002);

    // Randomized back-to-back jobs.
    for (int i = 0; i < 300; i++) begin
      nn = ($urandom_range(0, 29) == 0);
      nz = ($urandom_range(0, 19) == 0);
      sg = $urandom_range(0, 1);
      st = $urandom_range(0, 1);
      fr = FRAC_W'($urandom);
      if ($urandom_range(0, 3) == 0) sc = $urandom_range(0, 255) - 128;
      else sc = $urandom_range(0, 123) - 62;
      k = regime_k(sc);
      lat = (nn || nz || k >= N - 2 || k <= -(N - 1)) ? 1 : N + 1;
      encode("rand", nn, nz, sg, sc, fr, st, lat, model(nn, nz, sg, sc, fr, st));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
